wb_stage: RTL and testbench

Write-back stage of the 5-stage RISC-V pipeline. It holds the MEM/WB entry and waits for the data-memory load response, applying backpressure to MEM while it waits. It aligns and extends load data, then selects the result (ALU, load or PC+4). It drives the registered wb_rd/wb_data/wb_regwrite write port consumed by the decode stage's register file, and keeps a retired-instruction counter.

---
 rtl/wb_pkg.sv | 29 ++
 rtl/wb_stage_if.sv | 27 ++
 rtl/load_align.sv | 49 ++++
 rtl/wb_stage.sv | 117 +++++++++++
 tb/tb_wb_stage.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the write-back stage.
//   - load funct3 encodings (LB/LH/LW/LBU/LHU)
//   - stage state (EMPTY / HOLD)
//   - the MEM/WB entry captured when an instruction is accepted from MEM
package wb_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } wb_state_e;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] alu_result;
    logic [31:0] pc_plus4;
    logic        regwrite;
    logic        to_reg;
    logic        memread;
    logic        jump;
    logic [2:0]  funct3;
  } wb_entry_t;

endpackage

// File: rtl/wb_stage_if.sv
// MEM -> WB instruction bundle plus the stall handshake back to MEM.
//   master : MEM stage (drives mem_*, observes wb_stall)
//   slave  : WB stage  (observes mem_*, drives wb_stall)
interface wb_stage_if;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_pc_plus4;
  logic        mem_regwrite;
  logic        mem_to_reg;
  logic        mem_memread;
  logic        mem_jump;
  logic [2:0]  mem_funct3;
  logic        wb_stall;

  modport master (
    output mem_valid, mem_rd, mem_alu_result, mem_pc_plus4, mem_regwrite,
           mem_to_reg, mem_memread, mem_jump, mem_funct3,
    input  wb_stall
  );

  modport slave (
    input  mem_valid, mem_rd, mem_alu_result, mem_pc_plus4, mem_regwrite,
           mem_to_reg, mem_memread, mem_jump, mem_funct3,
    output wb_stall
  );
endinterface

// File: rtl/load_align.sv
// Combinational load data aligner.
//   funct3              : load size/sign selector
//   off                 : byte offset within the word (address bits [1:0])
//   raw                 : word returned by data memory
//   data                : selected and sign/zero-extended load value
//   misalign_or_illegal : offset not legal for the size, or funct3 not a load
module load_align
  import wb_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] raw,
  output logic [31:0] data,
  output logic        misalign_or_illegal
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (off)
      2'd0:    byte_sel = raw[7:0];
      2'd1:    byte_sel = raw[15:8];
      2'd2:    byte_sel = raw[23:16];
      default: byte_sel = raw[31:24];
    endcase
    half_sel = off[1] ? raw[31:16] : raw[15:0];
  end

  always_comb begin
    data                = raw;
    misalign_or_illegal = 1'b0;
    case (funct3)
      F3_LB:  data = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU: data = {24'd0, byte_sel};
      F3_LH: begin
        data                = {{16{half_sel[15]}}, half_sel};
        misalign_or_illegal = off[0];
      end
      F3_LHU: begin
        data                = {16'd0, half_sel};
        misalign_or_illegal = off[0];
      end
      F3_LW:   misalign_or_illegal = (off != 2'd0);
      default: misalign_or_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: holds one MEM/WB entry, waits for the load response
// (stalling MEM meanwhile), aligns load data, selects the result and drives
// the registered register-file write port plus a retired-instruction counter.
//   clock, reset   : clock and synchronous active-high reset
//   mem            : MEM bundle in, wb_stall out (combinational)
//   dmem_rsp_*     : load response from data memory
//   wb_rd/wb_data/wb_regwrite : registered register-file write port
//   load_err       : one-cycle pulse on a misaligned, illegal or timed-out load
//   instret        : count of error-free retirements
module wb_stage
  import wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int INSTRET_W      = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  wb_stage_if.slave            mem,
  input  logic                 dmem_rsp_valid,
  input  logic [31:0]          dmem_rsp_data,
  output logic [4:0]           wb_rd,
  output logic [31:0]          wb_data,
  output logic                 wb_regwrite,
  output logic                 load_err,
  output logic [INSTRET_W-1:0] instret
);

  // The counter only has to reach TIMEOUT_CYCLES-1.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  wb_state_e        state_reg;
  wb_entry_t        entry_reg;
  wb_entry_t        entry_next;
  logic [CNT_W-1:0] wait_cnt_reg;

  logic        hold;
  logic        is_load;
  logic        timeout;
  logic        stall;
  logic        retire;
  logic        accept;
  logic        err;
  logic [31:0] load_data;
  logic        misalign;
  logic [31:0] result;

  load_align u_align (
    .funct3              (entry_reg.funct3),
    .off                 (entry_reg.alu_result[1:0]),
    .raw                 (dmem_rsp_data),
    .data                (load_data),
    .misalign_or_illegal (misalign)
  );

  always_comb begin
    entry_next.rd         = mem.mem_rd;
    entry_next.alu_result = mem.mem_alu_result;
    entry_next.pc_plus4   = mem.mem_pc_plus4;
    entry_next.regwrite   = mem.mem_regwrite;
    entry_next.to_reg     = mem.mem_to_reg;
    entry_next.memread    = mem.mem_memread;
    entry_next.jump       = mem.mem_jump;
    entry_next.funct3     = mem.mem_funct3;
  end

  assign hold    = (state_reg == HOLD);
  assign is_load = hold && entry_reg.memread && entry_reg.to_reg;
  assign timeout = is_load && !dmem_rsp_valid && (wait_cnt_reg == CNT_LAST);
  assign stall   = is_load && !dmem_rsp_valid && !timeout;
  assign retire  = hold && !stall;
  assign accept  = mem.mem_valid && !stall;

  assign mem.wb_stall = stall;

  // A response arriving in the timeout cycle takes precedence over the timeout.
  assign err = is_load && (dmem_rsp_valid ? misalign : timeout);

  always_comb begin
    if (entry_reg.jump)        result = entry_reg.pc_plus4;
    else if (entry_reg.to_reg) result = load_data;
    else                       result = entry_reg.alu_result;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= EMPTY;
      entry_reg    <= '0;
      wait_cnt_reg <= '0;
      wb_rd        <= '0;
      wb_data      <= '0;
      wb_regwrite  <= 1'b0;
      load_err     <= 1'b0;
      instret      <= '0;
    end else begin
      // Accepting a new entry on a retire edge keeps throughput at one per cycle.
      if (accept) begin
        entry_reg <= entry_next;
        state_reg <= HOLD;
      end else if (retire) begin
        state_reg <= EMPTY;
      end

      if (retire)     wait_cnt_reg <= '0;
      else if (stall) wait_cnt_reg <= wait_cnt_reg + 1'b1;

      wb_regwrite <= retire && entry_reg.regwrite && (entry_reg.rd != 5'd0) && !err;
      load_err    <= retire && err;
      if (retire) begin
        wb_rd   <= entry_reg.rd;
        wb_data <= result;
        if (!err) instret <= instret + INSTRET_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;
  import wb_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        dmem_rsp_valid = 1'b0;
  logic [31:0] dmem_rsp_data  = '0;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_regwrite;
  logic        load_err;
  logic [63:0] instret;

  int n_cmp = 0;
  int n_bad = 0;

  wb_stage_if mem_bus ();

  wb_stage #(.TIMEOUT_CYCLES(4), .INSTRET_W(64)) dut (
    .clock          (clock),
    .reset          (reset),
    .mem            (mem_bus.slave),
    .dmem_rsp_valid (dmem_rsp_valid),
    .dmem_rsp_data  (dmem_rsp_data),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .wb_regwrite    (wb_regwrite),
    .load_err       (load_err),
    .instret        (instret)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_entry(input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] pc4,
                           input logic rw, input logic to_reg, input logic rd_mem,
                           input logic jump, input logic [2:0] f3);
    mem_bus.mem_valid      = 1'b1;
    mem_bus.mem_rd         = rd;
    mem_bus.mem_alu_result = alu;
    mem_bus.mem_pc_plus4   = pc4;
    mem_bus.mem_regwrite   = rw;
    mem_bus.mem_to_reg     = to_reg;
    mem_bus.mem_memread    = rd_mem;
    mem_bus.mem_jump       = jump;
    mem_bus.mem_funct3     = f3;
  endtask

  task automatic idle();
    mem_bus.mem_valid = 1'b0;
  endtask

  // Present a load, accept it, stall for n_stall cycles, then either respond or
  // let it time out. Leaves time just after the retire edge.
  task automatic run_load(input logic [4:0] rd, input logic [31:0] alu, input logic [2:0] f3,
                          input int n_stall, input logic respond, input logic [31:0] raw);
    set_entry(rd, alu, 32'd0, 1'b1, 1'b1, 1'b1, 1'b0, f3);
    tick();
    idle();
    for (int i = 0; i < n_stall; i++) begin
      #1 check("stall_wait", 64'(mem_bus.wb_stall), 64'd1);
      tick();
    end
    dmem_rsp_valid = respond;
    dmem_rsp_data  = raw;
    #1 check("stall_release", 64'(mem_bus.wb_stall), 64'd0);
    tick();
    dmem_rsp_valid = 1'b0;
  endtask

  task automatic run_alu(input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] pc4,
                         input logic jump);
    set_entry(rd, alu, pc4, 1'b1, 1'b0, 1'b0, jump, 3'b000);
    tick();
    idle();
    tick();
  endtask

  initial begin
    set_entry(5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    idle();
    repeat (2) tick();
    check("rst_rd", 64'(wb_rd), 64'd0);
    check("rst_data", 64'(wb_data), 64'd0);
    check("rst_regwrite", 64'(wb_regwrite), 64'd0);
    check("rst_load_err", 64'(load_err), 64'd0);
    check("rst_instret", instret, 64'd0);
    check("rst_stall", 64'(mem_bus.wb_stall), 64'd0);
    reset = 1'b0;
    tick();

    // 1: ADD
    run_alu(5'd5, 32'h0000_0042, 32'd0, 1'b0);
    check("add_regwrite", 64'(wb_regwrite), 64'd1);
    check("add_rd", 64'(wb_rd), 64'd5);
    check("add_data", 64'(wb_data), 64'h42);
    check("add_instret", instret, 64'd1);
    tick();
    check("add_strobe_drop", 64'(wb_regwrite), 64'd0);

    // 2: byte/half alignment, response in the same cycle
    run_load(5'd6, 32'h0000_1003, F3_LB, 0, 1'b1, 32'h80FF_FF7F);
    check("lb_data", 64'(wb_data), 64'hFFFF_FF80);
    check("lb_regwrite", 64'(wb_regwrite), 64'd1);
    run_load(5'd6, 32'h0000_1003, F3_LBU, 0, 1'b1, 32'h80FF_FF7F);
    check("lbu_data", 64'(wb_data), 64'h0000_0080);
    run_load(5'd6, 32'h0000_1002, F3_LHU, 0, 1'b1, 32'h80FF_FF7F);
    check("lhu_data", 64'(wb_data), 64'h0000_80FF);
    check("lhu_instret", instret, 64'd4);

    // 3: LW 3 cycles late with an ALU op queued behind it
    set_entry(5'd7, 32'h0000_2000, 32'd0, 1'b1, 1'b1, 1'b1, 1'b0, F3_LW);
    tick();
    set_entry(5'd8, 32'h0000_0099, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
    for (int i = 0; i < 3; i++) begin
      #1 check("lw_stall", 64'(mem_bus.wb_stall), 64'd1);
      check("lw_no_write", 64'(wb_regwrite), 64'd0);
      tick();
    end
    dmem_rsp_valid = 1'b1;
    dmem_rsp_data  = 32'h1234_5678;
    #1 check("lw_release", 64'(mem_bus.wb_stall), 64'd0);
    tick();
    dmem_rsp_valid = 1'b0;
    idle();
    check("lw_rd", 64'(wb_rd), 64'd7);
    check("lw_data", 64'(wb_data), 64'h1234_5678);
    check("lw_regwrite", 64'(wb_regwrite), 64'd1);
    check("lw_load_err", 64'(load_err), 64'd0);
    tick();
    check("b2b_rd", 64'(wb_rd), 64'd8);
    check("b2b_data", 64'(wb_data), 64'h99);
    check("b2b_regwrite", 64'(wb_regwrite), 64'd1);
    check("b2b_instret", instret, 64'd6);

    // 4: misaligned LH, illegal funct3, rd=0
    run_load(5'd9, 32'h0000_3001, F3_LH, 0, 1'b1, 32'hAAAA_BBBB);
    check("lh_mis_err", 64'(load_err), 64'd1);
    check("lh_mis_regwrite", 64'(wb_regwrite), 64'd0);
    check("lh_mis_rd", 64'(wb_rd), 64'd9);
    check("lh_mis_instret", instret, 64'd6);
    tick();
    check("err_pulse_drop", 64'(load_err), 64'd0);
    run_load(5'd9, 32'h0000_3000, 3'b011, 1, 1'b1, 32'h0);
    check("illegal_err", 64'(load_err), 64'd1);
    check("illegal_instret", instret, 64'd6);
    run_alu(5'd0, 32'h0000_0055, 32'd0, 1'b0);
    check("rd0_regwrite", 64'(wb_regwrite), 64'd0);
    check("rd0_data", 64'(wb_data), 64'h55);
    check("rd0_instret", instret, 64'd7);

    // 5: timeout after 3 stall cycles; response in the timeout cycle wins
    run_load(5'd10, 32'h0000_4000, F3_LW, 3, 1'b0, 32'h0);
    check("to_err", 64'(load_err), 64'd1);
    check("to_regwrite", 64'(wb_regwrite), 64'd0);
    check("to_instret", instret, 64'd7);
    run_load(5'd11, 32'h0000_4002, F3_LHU, 3, 1'b1, 32'hABCD_1234);
    check("to_race_err", 64'(load_err), 64'd0);
    check("to_race_regwrite", 64'(wb_regwrite), 64'd1);
    check("to_race_data", 64'(wb_data), 64'h0000_ABCD);
    check("to_race_instret", instret, 64'd8);

    // 6: JAL, then reset during a load stall
    run_alu(5'd1, 32'h0000_DEAD, 32'h0000_1004, 1'b1);
    check("jal_data", 64'(wb_data), 64'h1004);
    check("jal_rd", 64'(wb_rd), 64'd1);
    check("jal_instret", instret, 64'd9);
    set_entry(5'd12, 32'h0000_5000, 32'd0, 1'b1, 1'b1, 1'b1, 1'b0, F3_LW);
    tick();
    idle();
    tick();
    #1 check("pre_rst_stall", 64'(mem_bus.wb_stall), 64'd1);
    reset = 1'b1;
    tick();
    check("midrst_regwrite", 64'(wb_regwrite), 64'd0);
    check("midrst_data", 64'(wb_data), 64'd0);
    check("midrst_rd", 64'(wb_rd), 64'd0);
    check("midrst_instret", instret, 64'd0);
    check("midrst_stall", 64'(mem_bus.wb_stall), 64'd0);
    reset = 1'b0;
    dmem_rsp_valid = 1'b1;
    tick();
    dmem_rsp_valid = 1'b0;
    tick();
    check("post_rst_no_write", 64'(wb_regwrite), 64'd0);
    check("post_rst_instret", instret, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
